// File: rtl/datapath_pkg.sv
// Datapath-wide shared types.
package datapath_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Types shared by the direct-mapped instruction cache.
package icache_pkg;
  typedef datapath_pkg::word_t word_t;

  localparam int unsigned ICACHE_NSETS = 16;
  localparam int unsigned ICACHE_IDXW  = $clog2(ICACHE_NSETS);
  localparam int unsigned ICACHE_TAGW  = 32 - 3 - ICACHE_IDXW;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic                   blkoff;
    logic [1:0]             bytoff;
  } icache_addr_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t [1:0]            data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } icache_state_t;
endpackage

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a blocking two-word block fill.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned NSETS  = ICACHE_NSETS,
  parameter int unsigned WORD_W = $bits(word_t)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  icache_state_t state, next_state;
  icache_frame_t frames [NSETS];
  icache_frame_t sel;
  icache_addr_t  req, miss_addr;
  word_t         buf0;
  logic          hit_ev, miss_ev;
  logic          unused_addr_bits;

  assign req = icache_addr_t'(imemaddr);
  assign sel = frames[req.idx];
  assign unused_addr_bits = &{req.bytoff, miss_addr.bytoff, miss_addr.blkoff};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    hit_ev     = 1'b0;
    miss_ev    = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (sel.valid && (sel.tag == req.tag)) begin
            ihit     = 1'b1;
            imemload = sel.data[req.blkoff];
            hit_ev   = 1'b1;
          end else begin
            miss_ev    = 1'b1;
            next_state = FETCH0;
          end
        end
      end
      FETCH0: begin
        iREN  = 1'b1;
        iaddr = {miss_addr.tag, miss_addr.idx, 3'b000};
        if (!iwait) next_state = FETCH1;
      end
      FETCH1: begin
        iREN  = 1'b1;
        iaddr = {miss_addr.tag, miss_addr.idx, 3'b100};
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Tags and data survive reset; only valid bits are cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_addr  <= '0;
      buf0       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int unsigned i = 0; i < NSETS; i++) frames[i].valid <= 1'b0;
    end else begin
      if (hit_ev)  hit_count  <= hit_count + 32'd1;
      if (miss_ev) begin
        miss_count <= miss_count + 32'd1;
        miss_addr  <= req;
      end
      if (state == FETCH0 && !iwait) buf0 <= iload;
      if (state == FETCH1 && !iwait) begin
        frames[miss_addr.idx].valid   <= 1'b1;
        frames[miss_addr.idx].tag     <= miss_addr.tag;
        frames[miss_addr.idx].data[0] <= buf0;
        frames[miss_addr.idx].data[1] <= iload;
      end
    end
  end

endmodule
